ecc_apb_sequencer: RTL and testbench

ECC_APB_SEQUENCER -- requirements
Module: ecc_apb_sequencer

---
 rtl/ecc_apb_sequencer_if.sv | 49 ++++
 rtl/ecc_apb_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_ecc_apb_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ecc_apb_sequencer_if.sv
// Job, result, APB master and ECC status signals of the ECC APB sequencer.
// master = sequencer side, slave = job source / APB slave / ECC engine side.
interface ecc_apb_sequencer_if #(
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32
) ();
  logic                       req_valid;
  logic                       req_ready;
  logic [1:0]                 req_op;
  logic [1:0]                 req_width;
  logic [DATA_WIDTH-1:0]      req_data;
  logic [DATA_WIDTH-1:0]      req_noise;

  logic                       rsp_valid;
  logic [DATA_WIDTH-1:0]      rsp_data;
  logic [1:0]                 rsp_errors;
  logic                       rsp_timeout;
  logic                       busy;

  logic                       psel;
  logic                       penable;
  logic                       pwrite;
  logic [AMBA_ADDR_WIDTH-1:0] paddr;
  logic [AMBA_WORD-1:0]       pwdata;
  logic [AMBA_WORD-1:0]       prdata;

  logic                       operation_done;
  logic [DATA_WIDTH-1:0]      data_out;
  logic [1:0]                 num_of_errors;

  modport master (
    input  req_valid, req_op, req_width, req_data, req_noise,
    output req_ready,
    output rsp_valid, rsp_data, rsp_errors, rsp_timeout, busy,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata,
    input  operation_done, data_out, num_of_errors
  );

  modport slave (
    output req_valid, req_op, req_width, req_data, req_noise,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_errors, rsp_timeout, busy,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata,
    output operation_done, data_out, num_of_errors
  );
endinterface

// File: rtl/ecc_apb_sequencer.sv
// Runs one ECC job as APB writes (WIDTH, DATA, [NOISE], CTRL), then waits for done or timeout.
// Define ECC_SEQ_NOISE_EN to write the NOISE register for full-channel jobs.
module ecc_apb_sequencer #(
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT         = 255
) (
  input logic                 clk,
  input logic                 rst,
  ecc_apb_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 2);

  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL  = AMBA_ADDR_WIDTH'(8'h00);
  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA  = AMBA_ADDR_WIDTH'(8'h04);
  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_WIDTH = AMBA_ADDR_WIDTH'(8'h08);
  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE = AMBA_ADDR_WIDTH'(8'h0C);

  localparam logic [1:0] OP_FULL = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WR_WIDTH,
    WR_DATA,
    WR_NOISE,
    WR_CTRL,
    WAIT_DONE,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  access_q, access_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [1:0]            op_q, op_d;
  logic [1:0]            width_q, width_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]            rsp_errors_q, rsp_errors_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

`ifdef ECC_SEQ_NOISE_EN
  logic [DATA_WIDTH-1:0] noise_q, noise_d;
  logic                  unused_prdata;
  assign unused_prdata = ^bus.prdata;
`else
  logic                  unused_inputs;
  assign unused_inputs = ^{bus.prdata, bus.req_noise};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      access_q      <= 1'b0;
      cnt_q         <= '0;
      op_q          <= '0;
      width_q       <= '0;
      data_q        <= '0;
      rsp_data_q    <= '0;
      rsp_errors_q  <= '0;
      rsp_timeout_q <= 1'b0;
`ifdef ECC_SEQ_NOISE_EN
      noise_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      access_q      <= access_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      width_q       <= width_d;
      data_q        <= data_d;
      rsp_data_q    <= rsp_data_d;
      rsp_errors_q  <= rsp_errors_d;
      rsp_timeout_q <= rsp_timeout_d;
`ifdef ECC_SEQ_NOISE_EN
      noise_q       <= noise_d;
`endif
    end
  end

  // access_q selects the APB phase inside each WR_* state: 0 = SETUP, 1 = ACCESS.
  always_comb begin
    state_d       = state_q;
    access_d      = 1'b0;
    cnt_d         = '0;
    cnt_inc       = cnt_q + CNT_W'(1);
    op_d          = op_q;
    width_d       = width_q;
    data_d        = data_q;
    rsp_data_d    = rsp_data_q;
    rsp_errors_d  = rsp_errors_q;
    rsp_timeout_d = rsp_timeout_q;
`ifdef ECC_SEQ_NOISE_EN
    noise_d       = noise_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          width_d = bus.req_width;
          data_d  = bus.req_data;
`ifdef ECC_SEQ_NOISE_EN
          noise_d = bus.req_noise;
`endif
          if (bus.req_op == OP_RSVD) begin
            state_d       = RESP;
            rsp_data_d    = '0;
            rsp_errors_d  = 2'b11;
            rsp_timeout_d = 1'b0;
          end else begin
            state_d = WR_WIDTH;
          end
        end
      end
      WR_WIDTH: begin
        access_d = ~access_q;
        if (access_q) state_d = WR_DATA;
      end
      WR_DATA: begin
        access_d = ~access_q;
        if (access_q) begin
`ifdef ECC_SEQ_NOISE_EN
          state_d = (op_q == OP_FULL) ? WR_NOISE : WR_CTRL;
`else
          state_d = WR_CTRL;
`endif
        end
      end
`ifdef ECC_SEQ_NOISE_EN
      WR_NOISE: begin
        access_d = ~access_q;
        if (access_q) state_d = WR_CTRL;
      end
`endif
      WR_CTRL: begin
        access_d = ~access_q;
        if (access_q) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // done wins over timeout when both land in the same cycle
        if (bus.operation_done) begin
          state_d       = RESP;
          rsp_data_d    = bus.data_out;
          rsp_errors_d  = bus.num_of_errors;
          rsp_timeout_d = 1'b0;
        end else if (cnt_inc >= CNT_W'(TIMEOUT)) begin
          state_d       = RESP;
          rsp_data_d    = '0;
          rsp_errors_d  = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic                       wr_active;
  logic [AMBA_ADDR_WIDTH-1:0] wr_addr;
  logic [AMBA_WORD-1:0]       wr_wdata;

  always_comb begin
    wr_active = 1'b0;
    wr_addr   = '0;
    wr_wdata  = '0;
    case (state_q)
      WR_WIDTH: begin
        wr_active = 1'b1;
        wr_addr   = ADDR_WIDTH;
        wr_wdata  = AMBA_WORD'(width_q);
      end
      WR_DATA: begin
        wr_active = 1'b1;
        wr_addr   = ADDR_DATA;
        wr_wdata  = AMBA_WORD'(data_q);
      end
`ifdef ECC_SEQ_NOISE_EN
      WR_NOISE: begin
        wr_active = 1'b1;
        wr_addr   = ADDR_NOISE;
        wr_wdata  = AMBA_WORD'(noise_q);
      end
`endif
      WR_CTRL: begin
        wr_active = 1'b1;
        wr_addr   = ADDR_CTRL;
        wr_wdata  = AMBA_WORD'(op_q);
      end
      default: begin
        wr_active = 1'b0;
        wr_addr   = '0;
        wr_wdata  = '0;
      end
    endcase
  end

  assign bus.psel        = wr_active;
  assign bus.penable     = wr_active & access_q;
  assign bus.pwrite      = wr_active;
  assign bus.paddr       = wr_addr;
  assign bus.pwdata      = wr_wdata;

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_errors  = rsp_errors_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// Directed, table-driven bench for ecc_apb_sequencer (TIMEOUT=255).
// Expected APB write lists follow ECC_SEQ_NOISE_EN if it is defined for the build.
module tb_ecc_apb_sequencer;
  localparam int AW = 32;
  localparam int WW = 32;
  localparam int DW = 32;
`ifdef ECC_SEQ_NOISE_EN
  localparam bit NOISE_EN = 1'b1;
`else
  localparam bit NOISE_EN = 1'b0;
`endif
  localparam int NEVER = 1000;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ecc_apb_sequencer_if #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(WW), .DATA_WIDTH(DW)) bus ();

  ecc_apb_sequencer #(
    .AMBA_ADDR_WIDTH(AW),
    .AMBA_WORD(WW),
    .DATA_WIDTH(DW),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  width;
    logic [31:0] data;
    logic [31:0] noise;
    int          done_at;   // WAIT_DONE cycle index (0-based) that sees done; NEVER = no done
    logic [31:0] dout;
    logic [1:0]  nerr;
    bit          early;     // pulse done during the first SETUP cycle (must be ignored)
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
    logic        exp_to;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] width,
                              input logic [31:0] data, input logic [31:0] noise,
                              input int done_at, input logic [31:0] dout,
                              input logic [1:0] nerr, input bit early,
                              input logic [31:0] exp_data, input logic [1:0] exp_err,
                              input logic exp_to);
    vec_t v;
    v.op = op; v.width = width; v.data = data; v.noise = noise;
    v.done_at = done_at; v.dout = dout; v.nerr = nerr; v.early = early;
    v.exp_data = exp_data; v.exp_err = exp_err; v.exp_to = exp_to;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.req_width = v.width;
    bus.req_data  = v.data;
    bus.req_noise = v.noise;
  endtask

  // Cycle 0: job is presented while the sequencer is idle.
  task automatic start_job(input vec_t v);
    @(negedge clk);
    check("accept_ready", {bus.req_ready, bus.busy}, {1'b1, 1'b0});
    drive_req(v);
  endtask

  task automatic finish_job(input vec_t v, input bit hold, input vec_t nxt);
    logic [31:0] wa[4];
    logic [31:0] wd[4];
    int nw;
    int exp_k;
    bit done_now;
    nw = 0;
    if (v.op != 2'd3) begin
      wa[0] = 32'h08; wd[0] = {30'd0, v.width};
      wa[1] = 32'h04; wd[1] = v.data;
      nw = 2;
      if (NOISE_EN && v.op == 2'd2) begin
        wa[2] = 32'h0C; wd[2] = v.noise;
        nw = 3;
      end
      wa[nw] = 32'h00; wd[nw] = {30'd0, v.op};
      nw++;
    end
    for (int i = 0; i < nw; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        @(negedge clk);
        check($sformatf("apb_w%0d_ph%0d", i, ph),
              {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.busy, bus.rsp_valid},
              {1'b1, 1'(ph), 1'b1, wa[i], wd[i], 1'b1, 1'b0});
        if (!hold) bus.req_valid = 1'b0;
        bus.operation_done = v.early && i == 0 && ph == 0;
        bus.data_out       = 32'hFFFF_FFFF;
        bus.num_of_errors  = 2'b11;
      end
    end
    if (v.op == 2'd3) exp_k = 1;
    else if (v.done_at > 254) exp_k = 256;
    else exp_k = v.done_at + 2;
    for (int k = 1; k <= exp_k; k++) begin
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
      if (k == exp_k) begin
        check("rsp",
              {bus.rsp_valid, bus.rsp_data, bus.rsp_errors, bus.rsp_timeout, bus.psel, bus.busy, bus.req_ready},
              {1'b1, v.exp_data, v.exp_err, v.exp_to, 1'b0, 1'b1, 1'b0});
        bus.operation_done = 1'b0;
      end else begin
        check("wait_quiet", {bus.rsp_valid, bus.psel, bus.penable, bus.busy}, 4'b0001);
        done_now = (v.done_at <= 254) && (k == v.done_at + 1);
        bus.operation_done = done_now;
        bus.data_out       = done_now ? v.dout : 32'hBAD0_BAD0;
        bus.num_of_errors  = done_now ? v.nerr : 2'b11;
      end
    end
    @(negedge clk);
    check("post_rsp",
          {bus.rsp_valid, bus.busy, bus.req_ready, bus.psel, bus.rsp_data, bus.rsp_errors, bus.rsp_timeout},
          {1'b0, 1'b0, 1'b1, 1'b0, v.exp_data, v.exp_err, v.exp_to});
    if (hold) begin
      // second job accepted this cycle; a done pulse in IDLE must not be captured
      drive_req(nxt);
      bus.operation_done = 1'b1;
      bus.data_out       = 32'h1111_2222;
      bus.num_of_errors  = 2'b10;
    end else begin
      bus.req_valid = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t b1;
    vec_t b2;
    vec_t r1;
    checks   = 0;
    failures = 0;
    //           op    w     data           noise          done_at dout           nerr  early exp_data       err    to
    vecs[0] = mk(2'd0, 2'd0, 32'h0000_005A, 32'h0,         0,      32'h0000_05A3, 2'd0, 1'b0, 32'h0000_05A3, 2'd0, 1'b0);
    vecs[1] = mk(2'd1, 2'd1, 32'h0000_ABCD, 32'h55,        5,      32'h0000_00AB, 2'd1, 1'b1, 32'h0000_00AB, 2'd1, 1'b0);
    vecs[2] = mk(2'd2, 2'd2, 32'hDEAD_BEEF, 32'h1,         3,      32'hCAFE_F00D, 2'd1, 1'b0, 32'hCAFE_F00D, 2'd1, 1'b0);
    vecs[3] = mk(2'd2, 2'd2, 32'h0F0F_0F0F, 32'h8000_0000, 254,    32'h0000_1357, 2'd2, 1'b0, 32'h0000_1357, 2'd2, 1'b0);
    vecs[4] = mk(2'd0, 2'd1, 32'h0000_FFFF, 32'h0,         NEVER,  32'h0,         2'd0, 1'b0, 32'h0,         2'd0, 1'b1);
    vecs[5] = mk(2'd3, 2'd0, 32'h0000_0077, 32'h0,         NEVER,  32'h0,         2'd0, 1'b0, 32'h0,         2'b11, 1'b0);
    vecs[6] = mk(2'd1, 2'd0, 32'h0000_003C, 32'h0,         1,      32'h0000_03C0, 2'd3, 1'b0, 32'h0000_03C0, 2'd3, 1'b0);
    b1      = mk(2'd0, 2'd2, 32'h1234_5678, 32'h0,         2,      32'h0000_0ABC, 2'd0, 1'b0, 32'h0000_0ABC, 2'd0, 1'b0);
    b2      = mk(2'd2, 2'd1, 32'h0000_4321, 32'h0000_0009, 0,      32'h0000_0777, 2'd1, 1'b0, 32'h0000_0777, 2'd1, 1'b0);
    r1      = mk(2'd1, 2'd0, 32'h0000_0099, 32'h0,         0,      32'h0000_0990, 2'd0, 1'b0, 32'h0000_0990, 2'd0, 1'b0);

    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_width = '0;
    bus.req_data = '0; bus.req_noise = '0; bus.prdata = '0;
    bus.operation_done = 1'b0; bus.data_out = '0; bus.num_of_errors = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.rsp_valid,
           bus.rsp_data, bus.rsp_errors, bus.rsp_timeout, bus.busy, bus.req_ready},
          {3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1});
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      start_job(vecs[i]);
      finish_job(vecs[i], 1'b0, vecs[i]);
    end

    // Back-to-back jobs with req_valid held high throughout.
    start_job(b1);
    finish_job(b1, 1'b1, b2);
    finish_job(b2, 1'b0, b2);

    // Reset asserted during the WR_DATA ACCESS cycle.
    start_job(r1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
    check("pre_reset_access", {bus.psel, bus.penable, bus.paddr}, {1'b1, 1'b1, 32'h04});
    #2 rst = 1'b0;
    #1 check("async_reset",
             {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.busy, bus.req_ready, bus.rsp_valid},
             {1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("after_release",
          {bus.psel, bus.penable, bus.busy, bus.rsp_valid, bus.rsp_data, bus.rsp_timeout},
          {1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0});
    start_job(r1);
    finish_job(r1, 1'b0, r1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
